resize_axis_packer: RTL and testbench



---
 rtl/resize_pkg.sv | 15 +
 rtl/resize_axis_packer_if.sv | 15 +
 rtl/sync_fifo_fwft.sv | 55 +++++
 rtl/resize_axis_packer.sv | 120 ++++++++++++
 tb/tb_resize_axis_packer.sv | 163 ++++++++++++++++
 5 files changed

// File: rtl/resize_pkg.sv
// Shared constants and state encoding for the resize output packer.
//   PIX_W  : pixel width (packed RGB888)
//   W_BITS : width of the output-width configuration and x counter
//   H_BITS : width of the output-height configuration and y counter
package resize_pkg;
  localparam int PIX_W  = 24;
  localparam int W_BITS = 12;
  localparam int H_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_ERR  = 2'd2
  } state_t;
endpackage

// File: rtl/resize_axis_packer_if.sv
// AXI4-Stream video bus (tuser = SOF, tlast = EOL).
//   master : drives tdata/tvalid/tuser/tlast, samples tready
//   slave  : samples tdata/tvalid/tuser/tlast, drives tready
interface resize_axis_packer_if #(
  parameter int W = 24
);
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tready;
  logic         tuser;
  logic         tlast;

  modport master (output tdata, tvalid, tuser, tlast, input tready);
  modport slave  (input tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/sync_fifo_fwft.sv
// Synchronous first-word-fall-through FIFO.
//   clk/reset : clock, synchronous active-high reset
//   flush     : synchronous empty, same effect as reset
//   wr_en/wr_data : write request; accepted when not full, or when full
//                   and a read happens in the same cycle
//   rd_en     : pop the head word (ignored when empty)
//   rd_data   : head word, valid whenever empty is low
//   full/empty/count : occupancy status
module sync_fifo_fwft #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 24,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             wr_ok, rd_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];
  assign rd_ok   = rd_en && !empty;
  // at full the slot being written is the one freed by the same-cycle read
  assign wr_ok   = wr_en && (!full || rd_ok);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/resize_axis_packer.sv
// Packs the resize stage's free-running pixel stream into an AXI4-Stream
// video stream (tuser = SOF, tlast = EOL) behind a small skid FIFO.
//   clk, reset     : clock, synchronous active-high reset
//   enable         : permits a new frame to start from IDLE
//   out_width/out_height : frame geometry, latched at frame start
//   frame_restart  : abort frame, flush FIFO, clear overflow
//   valid_i/data_i : input pixels, no back-pressure
//   m_axis         : AXI4-Stream master
//   afull          : FIFO occupancy >= AFULL_LEVEL
//   overflow       : sticky, a pixel was dropped
//   frame_done     : pulse after the final pixel of a frame transfers
module resize_axis_packer
  import resize_pkg::*;
#(
  parameter int FIFO_DEPTH  = 16,
  parameter int AFULL_LEVEL = 12,
  parameter int PIX_W       = resize_pkg::PIX_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [W_BITS-1:0]   out_width,
  input  logic [H_BITS-1:0]   out_height,
  input  logic                frame_restart,
  input  logic                valid_i,
  input  logic [PIX_W-1:0]    data_i,
  resize_axis_packer_if.master m_axis,
  output logic                afull,
  output logic                overflow,
  output logic                frame_done
);
  localparam int AW = $clog2(FIFO_DEPTH);

  state_t             state;
  logic [W_BITS-1:0]  w_lat, x_cnt, w_last;
  logic [H_BITS-1:0]  h_lat, y_cnt, h_last;
  logic [PIX_W-1:0]   rd_data;
  logic [AW:0]        count;
  logic               full, empty, xfer, wr_en, drop, at_eol, at_eof;

  sync_fifo_fwft #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush   (frame_restart),
    .wr_en   (wr_en),
    .wr_data (data_i),
    .rd_en   (xfer),
    .rd_data (rd_data),
    .full    (full),
    .empty   (empty),
    .count   (count)
  );

  // a zero geometry wraps to all-ones here, which is the intended max-value treatment
  assign w_last = w_lat - 1'b1;
  assign h_last = h_lat - 1'b1;
  assign at_eol = (x_cnt == w_last);
  assign at_eof = at_eol && (y_cnt == h_last);

  assign xfer  = m_axis.tvalid && m_axis.tready;
  assign wr_en = (state == ST_RUN) && valid_i;
  assign drop  = (state == ST_RUN) && valid_i && full && !xfer;

  // sideband gated by tvalid so the idle bus reads all-zero
  assign m_axis.tvalid = !empty;
  assign m_axis.tdata  = empty ? '0 : rd_data;
  assign m_axis.tuser  = !empty && (x_cnt == '0) && (y_cnt == '0);
  assign m_axis.tlast  = !empty && at_eol;

  assign afull = (count >= (AW+1)'(AFULL_LEVEL));

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      w_lat      <= '0;
      h_lat      <= '0;
      x_cnt      <= '0;
      y_cnt      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else if (frame_restart) begin
      state      <= ST_IDLE;
      x_cnt      <= '0;
      y_cnt      <= '0;
      overflow   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (xfer) begin
        if (at_eol) begin
          x_cnt <= '0;
          y_cnt <= (y_cnt == h_last) ? '0 : y_cnt + 1'b1;
        end else begin
          x_cnt <= x_cnt + 1'b1;
        end
      end
      case (state)
        ST_IDLE: if (enable) begin
          // counter clear here overrides any leftover drain transfer
          state <= ST_RUN;
          w_lat <= out_width;
          h_lat <= out_height;
          x_cnt <= '0;
          y_cnt <= '0;
        end
        ST_RUN: begin
          if (xfer && at_eof) begin
            state      <= ST_IDLE;
            frame_done <= 1'b1;
          end else if (drop) begin
            state    <= ST_ERR;
            overflow <= 1'b1;
          end
        end
        ST_ERR:  ;
        default: state <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_resize_axis_packer.sv
module tb_resize_axis_packer;
  localparam int DEPTH = 16;
  localparam int AFL   = 12;
  localparam int M_IDLE = 0, M_RUN = 1, M_ERR = 2;

  logic        clk = 1'b0;
  logic        reset, enable, frame_restart, valid_i;
  logic [11:0] out_width;
  logic [10:0] out_height;
  logic [23:0] data_i;
  logic        afull, overflow, frame_done;

  resize_axis_packer_if #(.W(24)) axis ();

  resize_axis_packer #(.FIFO_DEPTH(DEPTH), .AFULL_LEVEL(AFL), .PIX_W(24)) dut (
    .clk           (clk),
    .reset         (reset),
    .enable        (enable),
    .out_width     (out_width),
    .out_height    (out_height),
    .frame_restart (frame_restart),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .m_axis        (axis),
    .afull         (afull),
    .overflow      (overflow),
    .frame_done    (frame_done)
  );

  always #5 clk = ~clk;

  // reference model: pixel queue plus linear pixel index within the frame
  logic [23:0] q[$];
  int m_mode, m_w, m_h, m_idx;
  bit m_ovf, m_done;
  int n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // compare outputs against the model, advance the model, then one clock
  task automatic tick();
    bit xfer, wr, drop, last;
    int pre;
    chk("tvalid", axis.tvalid, 32'(q.size() != 0));
    if (q.size() != 0) begin
      chk("tdata", axis.tdata, q[0]);
      chk("tuser", axis.tuser, 32'(m_idx == 0));
      chk("tlast", axis.tlast, 32'((m_idx % m_w) == m_w - 1));
    end
    chk("afull", afull, 32'(q.size() >= AFL));
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_done);
    xfer = (q.size() != 0) && axis.tready;
    if (reset) begin
      q.delete(); m_mode = M_IDLE; m_w = 1; m_h = 1; m_idx = 0; m_ovf = 0; m_done = 0;
    end else if (frame_restart) begin
      q.delete(); m_mode = M_IDLE; m_idx = 0; m_ovf = 0; m_done = 0;
    end else begin
      pre    = m_mode;
      m_done = 0;
      wr   = (pre == M_RUN) && valid_i && (q.size() < DEPTH || xfer);
      drop = (pre == M_RUN) && valid_i && q.size() == DEPTH && !xfer;
      if (xfer) begin
        void'(q.pop_front());
        last  = (m_idx == m_w * m_h - 1);
        m_idx = last ? 0 : m_idx + 1;
        if (last && pre == M_RUN) begin m_mode = M_IDLE; m_done = 1; end
      end
      if (wr) q.push_back(data_i);
      if (drop) begin m_ovf = 1; m_mode = M_ERR; end
      if (pre == M_IDLE && enable) begin
        m_mode = M_RUN; m_w = int'(out_width); m_h = int'(out_height); m_idx = 0;
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic px(input bit v, input logic [23:0] d, input bit rdy);
    valid_i = v; data_i = d; axis.tready = rdy;
    tick();
  endtask

  // pulse restart, load geometry, enable and take the IDLE->RUN cycle
  task automatic start_frame(input int w, input int h);
    valid_i = 0; axis.tready = 1; enable = 0;
    frame_restart = 1; tick(); frame_restart = 0;
    out_width = 12'(w); out_height = 11'(h); enable = 1;
    tick();
  endtask

  initial begin
    n_chk = 0; n_err = 0;
    m_mode = M_IDLE; m_w = 1; m_h = 1; m_idx = 0; m_ovf = 0; m_done = 0;
    reset = 1; enable = 0; frame_restart = 0; valid_i = 0; data_i = '0;
    out_width = 12'd4; out_height = 11'd2; axis.tready = 1;
    tick(); tick();
    reset = 0;
    chk("rst_tvalid", axis.tvalid, 0);
    chk("rst_tuser", axis.tuser, 0);
    chk("rst_tlast", axis.tlast, 0);

    // 4x2 frame, streaming
    enable = 1; tick();
    for (int i = 1; i <= 8; i++) px(1, 24'(i), 1);
    for (int i = 0; i < 4; i++) px(0, 0, 1);

    // 4x2 frame with a 6-cycle stall mid-line
    start_frame(4, 2);
    for (int i = 1; i <= 8; i++) px(1, 24'(16 + i), !(i >= 2 && i < 8));
    for (int i = 0; i < 8; i++) px(0, 0, 1);

    // overflow: 17 pixels into a stalled sink, drain, extra pixel ignored
    start_frame(8, 4);
    for (int i = 1; i <= 17; i++) px(1, 24'(32'h100 + i), 0);
    chk("ovf_set", overflow, 1);
    for (int i = 0; i < 18; i++) px(0, 0, 1);
    px(1, 24'hABCDEF, 1);
    px(0, 0, 1);

    // ERR with 5 buffered, restart, then a 1x3 frame
    start_frame(8, 4);
    for (int i = 1; i <= 17; i++) px(1, 24'(32'h200 + i), 0);
    for (int i = 0; i < 11; i++) px(0, 0, 1);
    axis.tready = 0; frame_restart = 1; out_width = 12'd1; out_height = 11'd3;
    tick(); frame_restart = 0;
    chk("rs_tvalid", axis.tvalid, 0);
    chk("rs_ovf", overflow, 0);
    tick();
    for (int i = 1; i <= 3; i++) px(1, 24'(32'h300 + i), 1);
    for (int i = 0; i < 4; i++) px(0, 0, 1);

    // random traffic with random geometry and occasional restarts
    for (int i = 0; i < 1500; i++) begin
      enable        = ($urandom_range(0, 9) != 0);
      out_width     = 12'($urandom_range(1, 5));
      out_height    = 11'($urandom_range(1, 4));
      frame_restart = ($urandom_range(0, 199) == 0);
      px($urandom_range(0, 9) < 6, 24'($urandom), $urandom_range(0, 9) < 7);
    end
    frame_restart = 0;

    // reset mid-line, then valid_i with enable low
    start_frame(5, 2);
    for (int i = 0; i < 3; i++) px(1, 24'($urandom), 0);
    reset = 1; px(1, 24'h1, 0); reset = 0;
    chk("mr_tvalid", axis.tvalid, 0);
    chk("mr_tdata", axis.tdata, 0);
    chk("mr_afull", afull, 0);
    enable = 0;
    for (int i = 0; i < 5; i++) px(1, 24'($urandom), 1);
    chk("mr_ovf", overflow, 0);
    chk("mr_tvalid_idle", axis.tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
